asp_irq_ctrl: RTL and testbench
===============================

Name: asp_irq_ctrl

Overview:
Parametrised ASP interrupt controller, the successor to the fixed 3-of-4-line IRQ bit assignment (DMA_0, kernel, DMA_1).
- Collects NUM_IRQ_LINES interrupt sources (DMAs, kernel, USM/VTP faults, ...).
- Latches each source into a per-line pending register with per-line enable and edge/level mode.
- Delivers one interrupt ID at a time to the shell MSI-X/user-IRQ port over a valid/ready handshake, arbitrated round-robin.
- Sits between the board-level IRQ sources and the host-channel IRQ port; software controls it through a 64-bit CSR window in ASP MMIO space.

Parameters:
- NUM_IRQ_LINES, 4, number of interrupt sources; 1..32.
- CSR_ADDR_WIDTH, 3, CSR word-address width (64-bit words).
- IRQ_ID_WIDTH, 5, width of delivered ID; must satisfy 2**IRQ_ID_WIDTH >= NUM_IRQ_LINES.
- DEFAULT_EDGE_MASK, 0, reset value of MODE register (bit=1: edge).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- irq_in  in  NUM_IRQ_LINES  source lines, already synchronous to clk.
- csr_address  in  CSR_ADDR_WIDTH  CSR word address.
- csr_write  in  1  write strobe.
- csr_writedata  in  64  write data.
- csr_read  in  1  read strobe.
- csr_readdata  out  64  read data.
- csr_readdatavalid  out  1  read response strobe.
- irq_valid  out  1  interrupt delivery request.
- irq_id  out  IRQ_ID_WIDTH  line index being delivered.
- irq_ready  in  1  shell accepts delivery.

Behaviour:
- Reset (reset_n=0 at a clk edge): PENDING=0, ENABLE=0, MODE=DEFAULT_EDGE_MASK, INFLIGHT=0, rr pointer=0, irq_prev=0, FSM=IDLE, irq_valid=0, irq_id=0, csr_readdatavalid=0, csr_readdata=0. A reset mid-handshake drops irq_valid the next cycle with no completion.
- CSR map (word addresses):
  - 0 PENDING, RO.
  - 1 ENABLE, RW.
  - 2 MODE, RW.
  - 3 CLEAR, WO: W1C on PENDING and INFLIGHT; reads return 0.
  - 4 INFO, RO: [7:0]=NUM_IRQ_LINES, [15:8]=IRQ_ID_WIDTH, [31:16]=0x0100 version.
  - 5 COALESCE, only with the optional feature; otherwise reads 0, writes ignored.
  - Unused bits read 0. Writes to RO or undefined addresses are ignored.
- Read latency: exactly 1 cycle. csr_readdatavalid pulses one cycle after csr_read. csr_read and csr_write in the same cycle are both honoured; a read of a register written that cycle returns the old value.
- Pending set:
  - Edge line: irq_in & ~irq_prev.
  - Level line: irq_in high.
  - PENDING updates the cycle after the event.
  - A set and a CLEAR in the same cycle: set wins.
  - A level line that is still asserted re-pends the cycle after a clear.
- Eligible = PENDING & ENABLE & ~INFLIGHT.
- FSM:
  - IDLE: if Eligible != 0, grant the first eligible line at or after rr pointer (wrapping modulo NUM_IRQ_LINES). Load irq_id, set irq_valid=1, go to REQ.
  - REQ: hold irq_valid and irq_id stable until irq_ready=1. On the accept cycle set INFLIGHT[irq_id]=1, rr pointer=irq_id+1 (wraps to 0 after NUM_IRQ_LINES-1), drop irq_valid, go to IDLE.
  - Disabling or clearing the granted line while in REQ does not withdraw the request.
- A line is not delivered again until software clears it through CLEAR, which clears INFLIGHT.
- Throughput: at most one delivery every 2 cycles.
- Latency from an edge on irq_in to irq_valid is 2 cycles when FSM=IDLE.

Optional Feature:
Macro ASP_IRQ_COALESCE_EN.
- Defined:
  - Adds COALESCE CSR (addr 5, [15:0] cycles, reset 0) and a 16-bit holdoff counter.
  - After each accept, the FSM enters HOLDOFF for COALESCE cycles before returning to IDLE; value 0 means no HOLDOFF state.
  - Pending and set logic keep running during HOLDOFF.
  - A write to COALESCE during HOLDOFF takes effect on the next holdoff.
- Not defined: no counter, no HOLDOFF state, address 5 reads 0.

Test Plan:
- Reset, read addr 4 -> readdata=0x0000_0000_0100_0504 one cycle later; PENDING=0, irq_valid=0.
- ENABLE=0xF, MODE=0xF, pulse irq_in[2] one cycle at T -> irq_valid=1, irq_id=2 at T+2; hold irq_ready=0 for 5 cycles -> id stable; ready=1 -> INFLIGHT[2]=1, no redelivery until CLEAR=0x4.
- Edge lines 0, 1, 3 pulsed together, ready tied 1 -> ids delivered 0, 1, 3; after CLEAR=0xB and new pulses on 0 and 3 -> next order 0, then 3 (rr pointer after 3 wraps to 0).
- Level mode line 1 (MODE=0xD) held high, CLEAR=0x2 -> PENDING[1] reads 1 again next cycle, redelivered; CLEAR in the same cycle as a new edge on an edge line -> pending stays 1.
- ENABLE=0, pulse line 0 -> PENDING=0x1, no irq_valid; write ENABLE=0x1 -> irq_valid two cycles later.
- ASP_IRQ_COALESCE_EN, COALESCE=10, lines 0 and 1 pending -> second irq_valid exactly 11 cycles after the first accept; assert reset_n=0 during REQ -> irq_valid=0 next cycle, all registers at reset values.

Source files
------------

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt controller: per-line pending/enable/mode, round-robin delivery over valid/ready.
// Optional ASP_IRQ_COALESCE_EN adds a COALESCE CSR and a post-accept HOLDOFF state.
`timescale 1ns/1ps
module asp_irq_ctrl #(
    parameter int NUM_IRQ_LINES  = 4,
    parameter int CSR_ADDR_WIDTH = 3,
    parameter int IRQ_ID_WIDTH   = 5,
    parameter logic [NUM_IRQ_LINES-1:0] DEFAULT_EDGE_MASK = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ_LINES-1:0]  irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
    input  logic                      csr_write,
    input  logic [63:0]               csr_writedata,
    input  logic                      csr_read,
    output logic [63:0]               csr_readdata,
    output logic                      csr_readdatavalid,
    output logic                      irq_valid,
    output logic [IRQ_ID_WIDTH-1:0]   irq_id,
    input  logic                      irq_ready
);
    localparam int N = NUM_IRQ_LINES;
    localparam logic [IRQ_ID_WIDTH-1:0]   LAST_ID      = IRQ_ID_WIDTH'(N - 1);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_PENDING = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_ENABLE  = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MODE    = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CLEAR   = CSR_ADDR_WIDTH'(3);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_INFO    = CSR_ADDR_WIDTH'(4);
`ifdef ASP_IRQ_COALESCE_EN
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_COAL    = CSR_ADDR_WIDTH'(5);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1
`ifdef ASP_IRQ_COALESCE_EN
        ,S_HOLDOFF = 2'd2
`endif
    } state_t;

    state_t                    state, state_n;
    logic [N-1:0]              pending, enable, mode, inflight, irq_prev;
    logic [N-1:0]              wdata, clr_mask, set_mask, eligible, accept_mask;
    logic [IRQ_ID_WIDTH-1:0]   rr_ptr, rr_ptr_n, irq_id_n, grant_id, hi_id, lo_id;
    logic                      irq_valid_n, grant_found, hi_found, lo_found, accept;
    logic [63:0]               rd_mux;
    logic                      unused_wdata;
`ifdef ASP_IRQ_COALESCE_EN
    logic [15:0]               coalesce, hold_cnt, hold_cnt_n;
`endif

    assign unused_wdata = ^csr_writedata[63:N];
    assign wdata        = csr_writedata[N-1:0];
    assign clr_mask     = (csr_write && csr_address == ADDR_CLEAR) ? wdata : '0;
    // Edge lines latch on the rising transition only; level lines whenever high.
    assign set_mask     = (mode & irq_in & ~irq_prev) | (~mode & irq_in);
    assign eligible     = pending & enable & ~inflight;
    assign accept_mask  = accept ? (N'(1) << irq_id) : '0;

    // Round-robin: lowest eligible line at/after rr_ptr, else lowest eligible overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_found = 1'b1;
                lo_id    = IRQ_ID_WIDTH'(i);
                if (IRQ_ID_WIDTH'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_id    = IRQ_ID_WIDTH'(i);
                end
            end
        end
        grant_found = lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        state_n     = state;
        irq_valid_n = irq_valid;
        irq_id_n    = irq_id;
        rr_ptr_n    = rr_ptr;
        accept      = 1'b0;
`ifdef ASP_IRQ_COALESCE_EN
        hold_cnt_n  = hold_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    irq_valid_n = 1'b1;
                    irq_id_n    = grant_id;
                    state_n     = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ready) begin
                    accept      = 1'b1;
                    irq_valid_n = 1'b0;
                    rr_ptr_n    = (irq_id == LAST_ID) ? '0 : irq_id + IRQ_ID_WIDTH'(1);
                    state_n     = S_IDLE;
`ifdef ASP_IRQ_COALESCE_EN
                    // The accept cycle counts as the first holdoff cycle.
                    if (coalesce > 16'd1) begin
                        state_n    = S_HOLDOFF;
                        hold_cnt_n = coalesce - 16'd1;
                    end
`endif
                end
            end
`ifdef ASP_IRQ_COALESCE_EN
            S_HOLDOFF: begin
                if (hold_cnt <= 16'd1) state_n = S_IDLE;
                else hold_cnt_n = hold_cnt - 16'd1;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            ADDR_PENDING: rd_mux[N-1:0] = pending;
            ADDR_ENABLE:  rd_mux[N-1:0] = enable;
            ADDR_MODE:    rd_mux[N-1:0] = mode;
            ADDR_INFO:    rd_mux[31:0]  = {16'h0100, 8'(IRQ_ID_WIDTH), 8'(NUM_IRQ_LINES)};
`ifdef ASP_IRQ_COALESCE_EN
            ADDR_COAL:    rd_mux[15:0]  = coalesce;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            irq_valid         <= 1'b0;
            irq_id            <= '0;
            rr_ptr            <= '0;
            pending           <= '0;
            enable            <= '0;
            mode              <= DEFAULT_EDGE_MASK;
            inflight          <= '0;
            irq_prev          <= '0;
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
`ifdef ASP_IRQ_COALESCE_EN
            coalesce          <= '0;
            hold_cnt          <= '0;
`endif
        end else begin
            state             <= state_n;
            irq_valid         <= irq_valid_n;
            irq_id            <= irq_id_n;
            rr_ptr            <= rr_ptr_n;
            irq_prev          <= irq_in;
            // A set in the same cycle as a clear wins.
            pending           <= (pending & ~clr_mask) | set_mask;
            inflight          <= (inflight & ~clr_mask) | accept_mask;
            if (csr_write && csr_address == ADDR_ENABLE) enable <= wdata;
            if (csr_write && csr_address == ADDR_MODE)   mode   <= wdata;
`ifdef ASP_IRQ_COALESCE_EN
            if (csr_write && csr_address == ADDR_COAL)   coalesce <= csr_writedata[15:0];
            hold_cnt          <= hold_cnt_n;
`endif
            csr_readdatavalid <= csr_read;
            csr_readdata      <= csr_read ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Scoreboard bench for asp_irq_ctrl: expected IDs and read data queued at stimulus, checked at output.
`timescale 1ns/1ps
module tb_asp_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  irq_in = '0;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [63:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ready = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [4:0]  id_q[$];
    logic [63:0] rd_q[$];
    int          acc_t[$];
    logic        rd_due = 1'b0;

    asp_irq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .irq_in(irq_in),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (irq_valid && irq_ready) begin
                acc_t.push_back(cyc);
                if (id_q.size() == 0) chk("unexpected_irq", 64'(irq_id), 64'h1f);
                else chk("irq_id", 64'(irq_id), 64'(id_q.pop_front()));
            end
            if (csr_readdatavalid || rd_due) chk("rd_latency", 64'(csr_readdatavalid), 64'(rd_due));
            if (csr_readdatavalid) begin
                if (rd_q.size() == 0) chk("unexpected_rd", 64'(csr_readdatavalid), 64'd0);
                else chk("rd_data", csr_readdata, rd_q.pop_front());
            end
        end
        rd_due = csr_read && reset_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [63:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [63:0] exp);
        csr_address = a; csr_read = 1'b1;
        rd_q.push_back(exp);
        tick();
        csr_read = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && id_q.size() != 0; i++) tick();
        chk("drain", 64'(id_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(irq_valid), 64'd0);
        chk("rst_id", 64'(irq_id), 64'd0);
        chk("rst_rdv", 64'(csr_readdatavalid), 64'd0);
        chk("rst_rdata", csr_readdata, 64'd0);
        reset_n = 1'b1;
        tick();
        csr_rd(3'd4, 64'h0000_0000_0100_0504);
        csr_rd(3'd0, 64'd0);
        csr_rd(3'd3, 64'd0);
        csr_rd(3'd7, 64'd0);

        // Edge delivery, held request, inflight blocking
        csr_wr(3'd1, '1);
        csr_rd(3'd1, 64'hF);
        csr_wr(3'd2, 64'hF);
        irq_in = 4'h4;
        tick();
        irq_in = '0;
        chk("lat_t1_valid", 64'(irq_valid), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(irq_valid), 64'd1);
        chk("lat_t2_id", 64'(irq_id), 64'd2);
        id_q.push_back(5'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 64'(irq_valid), 64'd1);
            chk("hold_id", 64'(irq_id), 64'd2);
        end
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        chk("drop_valid", 64'(irq_valid), 64'd0);
        pulse(4'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_redeliver", 64'(irq_valid), 64'd0);
        end
        csr_rd(3'd0, 64'h4);
        csr_wr(3'd3, 64'h4);
        csr_rd(3'd0, 64'd0);
        id_q.push_back(5'd2);
        irq_ready = 1'b1;
        pulse(4'h4);
        drain(10);

        // Round-robin order with wrap
        do_reset();
        csr_wr(3'd1, 64'hF);
        csr_wr(3'd2, 64'hF);
        irq_ready = 1'b1;
        acc_t.delete();
        id_q.push_back(5'd0); id_q.push_back(5'd1); id_q.push_back(5'd3);
        pulse(4'hB);
        drain(12);
        chk("rr_accepts", 64'(acc_t.size()), 64'd3);
        if (acc_t.size() == 3) begin
            chk("tput_gap1", 64'(acc_t[1] - acc_t[0]), 64'd2);
            chk("tput_gap2", 64'(acc_t[2] - acc_t[1]), 64'd2);
        end
        csr_wr(3'd3, 64'hB);
        id_q.push_back(5'd0); id_q.push_back(5'd3);
        pulse(4'h9);
        drain(12);

        // Level line re-pend after clear
        csr_wr(3'd3, 64'hF);
        csr_wr(3'd2, 64'hD);
        id_q.push_back(5'd1);
        irq_in = 4'h2;
        drain(10);
        id_q.push_back(5'd1);
        csr_wr(3'd3, 64'h2);
        csr_rd(3'd0, 64'h2);
        drain(10);
        irq_in = '0;
        tick();
        csr_wr(3'd3, 64'h2);
        csr_rd(3'd0, 64'd0);

        // Clear and edge in the same cycle: set wins
        csr_wr(3'd1, 64'd0);
        pulse(4'h1);
        csr_rd(3'd0, 64'h1);
        irq_in = 4'h1;
        csr_address = 3'd3; csr_writedata = 64'h1; csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
        irq_in = '0;
        csr_rd(3'd0, 64'h1);

        // Disabled pending line delivers two cycles after enable
        irq_ready = 1'b0;
        repeat (3) tick();
        chk("disabled_valid", 64'(irq_valid), 64'd0);
        csr_wr(3'd1, 64'h1);
        chk("en_t1_valid", 64'(irq_valid), 64'd0);
        tick();
        chk("en_t2_valid", 64'(irq_valid), 64'd1);
        chk("en_t2_id", 64'(irq_id), 64'd0);
        id_q.push_back(5'd0);
        irq_ready = 1'b1;
        drain(5);

        // Reset in the middle of a request
        irq_ready = 1'b0;
        csr_wr(3'd1, 64'hF);
        pulse(4'h8);
        tick();
        chk("req_valid", 64'(irq_valid), 64'd1);
        chk("req_id", 64'(irq_id), 64'd3);
        reset_n = 1'b0;
        tick();
        chk("midrst_valid", 64'(irq_valid), 64'd0);
        chk("midrst_id", 64'(irq_id), 64'd0);
        reset_n = 1'b1;
        csr_rd(3'd1, 64'd0);
        csr_rd(3'd2, 64'd0);
        csr_rd(3'd0, 64'd0);

        // Coalescing (or its absence in the default build)
        csr_wr(3'd1, 64'h3);
        csr_wr(3'd2, 64'h3);
        csr_wr(3'd5, 64'd10);
`ifdef ASP_IRQ_COALESCE_EN
        csr_rd(3'd5, 64'd10);
`else
        csr_rd(3'd5, 64'd0);
`endif
        acc_t.delete();
        id_q.push_back(5'd0); id_q.push_back(5'd1);
        irq_ready = 1'b1;
        pulse(4'h3);
        drain(30);
        chk("coal_accepts", 64'(acc_t.size()), 64'd2);
        if (acc_t.size() == 2) begin
`ifdef ASP_IRQ_COALESCE_EN
            chk("coal_gap", 64'(acc_t[1] - acc_t[0]), 64'd11);
`else
            chk("coal_gap", 64'(acc_t[1] - acc_t[0]), 64'd2);
`endif
        end

        repeat (3) tick();
        chk("id_q_empty", 64'(id_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end
endmodule
